blink_sequencer: RTL and testbench

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

---
 rtl/blink_sequencer.sv | 144 ++++++++++++++
 tb/tb_blink_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/blink_sequencer.sv
// blink_sequencer: configurable LED blink pattern generator.
// A prescaler produces ticks; every cfg_period ticks the blink phase flips.
// Each 1->0 phase flip completes one full period and advances the step count.
// The run stops when stop is asserted. If repeat is off, it also ends after
// NUM_STEPS full periods with a one-cycle done pulse.
module blink_sequencer #(
    parameter int PRESCALE  = 5,
    parameter int NUM_STEPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_period,
    input  logic [1:0] cfg_mode,
    input  logic       cfg_repeat,
    input  logic       start,
    input  logic       stop,
    output logic       tick,
    output logic [2:0] led,
    output logic       busy,
    output logic       done
);

    localparam int             PW           = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0]  PRESCALE_MAX = PW'(PRESCALE);
    localparam logic [7:0]     STEP_LAST    = 8'(NUM_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      period_reg;
    logic [1:0]      mode_reg;
    logic            repeat_reg;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [7:0]      half_reg, half_next;
    logic [7:0]      step_reg, step_next;
    logic            phase_reg, phase_next;
    logic [2:0]      led_reg, led_next;

    logic            cfg_load;
    logic            half_wrap;
    logic            period_end;
    logic            finish;
    logic [7:0]      step_inc;
    logic [7:0]      step_mod3;
    logic [2:0]      chase_led;

    assign cfg_ready = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign led       = led_reg;

    assign cfg_load   = cfg_valid && cfg_ready;
    assign tick       = (state_reg == RUN) && (presc_reg == PRESCALE_MAX);
    assign half_wrap  = tick && (half_reg == (period_reg - 8'd1));
    assign period_end = half_wrap && phase_reg;
    assign step_inc   = step_reg + 8'd1;
    assign finish     = period_end && !repeat_reg && (step_inc == STEP_LAST);

    // Chase pattern: one-hot position selected by step modulo 3
    assign step_mod3 = step_next % 8'd3;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chase
            assign chase_led[gi] = (step_mod3 == 8'(gi));
        end
    endgenerate

    // Configuration registers: loaded only on an accepted handshake in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_reg <= 8'd1;
            mode_reg   <= 2'd0;
            repeat_reg <= 1'b0;
        end else if (cfg_load) begin
            period_reg <= (cfg_period == 8'd0) ? 8'd1 : cfg_period;
            mode_reg   <= cfg_mode;
            repeat_reg <= cfg_repeat;
        end
    end

    // State and run-time counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            half_reg  <= 8'd0;
            step_reg  <= 8'd0;
            phase_reg <= 1'b0;
            led_reg   <= 3'b000;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            half_reg  <= half_next;
            step_reg  <= step_next;
            phase_reg <= phase_next;
            led_reg   <= led_next;
        end
    end

    // Next-state logic; stop always beats start and completion
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && !stop) state_next = RUN;
            RUN: begin
                if (stop)        state_next = IDLE;
                else if (finish) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter and LED update. Everything clears unless the run continues,
    // so each RUN entry starts from zero. The LED follows the new phase
    // in the same cycle.
    always_comb begin
        presc_next = '0;
        half_next  = 8'd0;
        step_next  = 8'd0;
        phase_next = 1'b0;
        led_next   = 3'b000;
        if (state_reg == RUN && state_next == RUN) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
            half_next  = half_wrap ? 8'd0 : (tick ? half_reg + 8'd1 : half_reg);
            phase_next = half_wrap ? ~phase_reg : phase_reg;
            step_next  = period_end ? step_inc : step_reg;
        end
        if (phase_next) begin
            case (mode_reg)
                2'd0:    led_next = 3'b111;
                2'd1:    led_next = chase_led;
                2'd2:    led_next = step_next[2:0];
                default: led_next = 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: table-driven runs with a per-cycle expectation queue,
// plus hand-written reset and start/stop corner sequences.
module tb_blink_sequencer;

    localparam int PRESCALE  = 1;
    localparam int NUM_STEPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [1:0] cfg_mode;
    logic       cfg_repeat;
    logic       start;
    logic       stop;
    logic       tick;
    logic [2:0] led;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Expected outputs {led[2:0], busy, done, tick, cfg_ready}, one per cycle
    logic [6:0] sb[$];

    typedef struct {
        logic       load;     // drive cfg_valid with the start cycle
        logic [7:0] period;   // driven cfg_period
        logic [1:0] mode;     // driven cfg_mode
        logic       rpt;      // driven cfg_repeat
        int         eff;      // expected effective half-period in ticks
        int         emode;    // expected effective mode
        int         stop_at;  // RUN cycle in which stop is driven (0 = never)
        int         done_at;  // RUN-relative cycle of the done pulse (0 = none)
        int         ncyc;     // cycles observed after start
    } vec_t;

    vec_t tbl[7];

    blink_sequencer #(
        .PRESCALE (PRESCALE),
        .NUM_STEPS(NUM_STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_period(cfg_period),
        .cfg_mode  (cfg_mode),
        .cfg_repeat(cfg_repeat),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Closed-form expectation for RUN-relative cycle n (cycle 1 = first RUN cycle)
    function automatic logic [6:0] exp_out(vec_t v, int n);
        int         t;
        int         half_len;
        int         ph;
        int         st;
        logic [2:0] l;
        logic       tk;
        t        = PRESCALE + 1;
        half_len = t * v.eff;
        if (v.stop_at != 0 && n > v.stop_at) return 7'b000_0001;
        if (v.done_at != 0 && n == v.done_at) return 7'b000_0100;
        if (v.done_at != 0 && n > v.done_at) return 7'b000_0001;
        ph = ((n - 1) / half_len) % 2;
        st = ((n - 1) / (2 * half_len)) % 256;
        l  = 3'b000;
        if (ph == 1) begin
            case (v.emode)
                0:       l = 3'b111;
                1:       l = 3'(1 << (st % 3));
                2:       l = st[2:0];
                default: l = 3'b000;
            endcase
        end
        tk = ((n % t) == 0);
        return {l, 1'b1, 1'b0, tk, 1'b0};
    endfunction

    task automatic check(input string name, input int n, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got led=%b busy=%b done=%b tick=%b rdy=%b, expected led=%b busy=%b done=%b tick=%b rdy=%b",
                     name, n, got[6:4], got[3], got[2], got[1], got[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [6:0] exp;
        logic [6:0] got;
        int         err0;
        err0 = errors;
        @(negedge clk);
        cfg_valid  = v.load;
        cfg_period = v.period;
        cfg_mode   = v.mode;
        cfg_repeat = v.rpt;
        start      = 1'b1;
        stop       = 1'b0;
        sb.push_back(exp_out(v, 1));
        for (int n = 1; n <= v.ncyc; n++) begin
            @(negedge clk);
            got = {led, busy, done, tick, cfg_ready};
            exp = sb.pop_front();
            check($sformatf("vec%0d", idx), n, got, exp);
            // While running: hold start high and offer conflicting config;
            // both must be ignored outside IDLE.
            start = exp[3];
            stop  = (v.stop_at != 0 && n == v.stop_at);
            if (exp[3]) begin
                cfg_valid  = 1'b1;
                cfg_period = 8'd9;
                cfg_mode   = 2'd3;
                cfg_repeat = ~v.rpt;
            end else begin
                cfg_valid = 1'b0;
            end
            if (n < v.ncyc) sb.push_back(exp_out(v, n + 1));
        end
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        $display("vec%0d period=%0d mode=%0d repeat=%0d stop_at=%0d: %0d cycles, %0d errors",
                 idx, v.period, v.mode, v.rpt, v.stop_at, v.ncyc, errors - err0);
    endtask

    initial begin
        //            load  period mode  rpt  eff emode stop done ncyc
        tbl[0] = '{1'b1, 8'd2,   2'd0, 1'b0, 2,  0,    0,   33,  36};
        tbl[1] = '{1'b1, 8'd2,   2'd1, 1'b0, 2,  1,    0,   33,  36};
        tbl[2] = '{1'b1, 8'd0,   2'd0, 1'b0, 1,  0,    0,   17,  20};
        tbl[3] = '{1'b1, 8'd2,   2'd0, 1'b0, 2,  0,    10,  0,   14};
        tbl[4] = '{1'b1, 8'd1,   2'd2, 1'b1, 1,  2,    42,  0,   45};
        tbl[5] = '{1'b1, 8'd3,   2'd3, 1'b0, 3,  3,    0,   49,  52};
        // After reset: nothing loaded, so defaults period=1, mode=0, repeat=0 apply
        tbl[6] = '{1'b0, 8'd200, 2'd3, 1'b1, 1,  0,    0,   17,  20};

        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        cfg_mode   = 2'd0;
        cfg_repeat = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        rst        = 1'b1;
        #1 rst = 1'b0;
        #1 check("reset_state", 0, {led, busy, done, tick, cfg_ready}, 7'b000_0001);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // stop and start together in IDLE: stop wins
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        check("idle_stop_beats_start", 1, {led, busy, done, tick, cfg_ready}, 7'b000_0001);
        start = 1'b0;
        stop  = 1'b0;
        $display("idle start+stop: busy=%b cfg_ready=%b", busy, cfg_ready);

        // Asynchronous reset in RUN cycle 7 of a chase run (led 001 at that point)
        @(negedge clk);
        cfg_valid  = 1'b1;
        cfg_period = 8'd2;
        cfg_mode   = 2'd1;
        cfg_repeat = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("pre_reset_run", 7, {led, busy, done, tick, cfg_ready}, 7'b001_1000);
        rst = 1'b0;
        #1;
        check("async_reset", 7, {led, busy, done, tick, cfg_ready}, 7'b000_0001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 0, {led, busy, done, tick, cfg_ready}, 7'b000_0001);
        $display("mid-run reset: led=%b busy=%b done=%b", led, busy, done);

        run_vec(tbl[6], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
